// File: rtl/sigma_delta_adc.sv
`default_nettype none
// ============================================================================
// Module   : sigma_delta_adc
// Brief    : First-order 1-bit sigma-delta ADC loop with 2nd-order CIC
//            decimator producing 16-bit offset-binary samples.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_delta_adc #(
    parameter int DECIM_LOG2 = 8,   // legal range 4..8
    parameter int WARMUP     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        comp_in,
    output logic        fb_out,
    output logic [15:0] sample,
    output logic        sample_valid
);

    localparam int c_W     = 2 * DECIM_LOG2 + 1;
    localparam int c_SHIFT = 16 - 2 * DECIM_LOG2;
    localparam int c_WCW   = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    logic                  r_s1;
    logic                  r_s2;
    logic                  r_fb;
    logic [c_W-1:0]        r_int1;
    logic [c_W-1:0]        r_int2;
    logic [c_W-1:0]        r_int2_d;
    logic [c_W-1:0]        r_c1;
    logic [c_W-1:0]        r_c1_d;
    logic [DECIM_LOG2-1:0] r_dcnt;
    logic                  r_out_stb;
    logic [c_WCW-1:0]      r_warm;
    logic [15:0]           r_sample;
    logic                  r_valid;

    logic                  w_tick;
    logic [c_W-1:0]        w_c2;
    logic [16:0]           w_full;
    logic [15:0]           w_sat;

    assign w_tick = &r_dcnt;
    // Second comb stage feeds the output register directly so the strobe
    // lands two cycles after the tick.
    assign w_c2   = r_c1 - r_c1_d;
    assign w_full = 17'(w_c2) << c_SHIFT;
    assign w_sat  = w_full[16] ? 16'hFFFF : w_full[15:0];

    // Only r_s1 ever samples the asynchronous pad bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_fb <= 1'b0;
        end else begin
            r_s1 <= comp_in;
            r_s2 <= r_s1;
            r_fb <= r_s2;
        end
    end

    // Integrators wrap modulo 2^c_W by design; the comb differences undo it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_int1 <= '0;
            r_int2 <= '0;
            r_dcnt <= '0;
        end else begin
            r_int1 <= r_int1 + c_W'(r_s2);
            r_int2 <= r_int2 + r_int1;
            r_dcnt <= r_dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_int2_d  <= '0;
            r_c1      <= '0;
            r_c1_d    <= '0;
            r_out_stb <= 1'b0;
            r_warm    <= '0;
            r_sample  <= 16'h8000;
            r_valid   <= 1'b0;
        end else begin
            r_out_stb <= w_tick;
            r_valid   <= 1'b0;
            if (w_tick) begin
                r_c1     <= r_int2 - r_int2_d;
                r_int2_d <= r_int2;
            end
            if (r_out_stb) begin
                r_c1_d <= r_c1;
                if (r_warm == c_WCW'(WARMUP)) begin
                    r_sample <= w_sat;
                    r_valid  <= 1'b1;
                end else begin
                    r_warm <= r_warm + 1'b1;
                end
            end
        end
    end

    assign fb_out       = r_fb;
    assign sample       = r_sample;
    assign sample_valid = r_valid;

endmodule
`default_nettype wire
